// File: rtl/xgmii_pkg.sv
// Shared XGMII definitions for the 10GbE transmit path: lane word type,
// control characters, constant cycle words, encoder states and tkeep decode.
`timescale 1ns/1ps
package xgmii_pkg;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  ctrl;
    } xgmii_t;

    localparam logic [7:0] XGMII_IDLE     = 8'h07;
    localparam logic [7:0] XGMII_START    = 8'hfb;
    localparam logic [7:0] XGMII_TERM     = 8'hfd;
    localparam logic [7:0] XGMII_ERROR    = 8'hfe;
    localparam logic [7:0] XGMII_PREAMBLE = 8'h55;
    localparam logic [7:0] XGMII_SFD      = 8'hd5;

    localparam xgmii_t XGMII_IDLE_WORD = '{data: {8{XGMII_IDLE}}, ctrl: 8'hff};
    localparam xgmii_t XGMII_ERROR_WORD = '{data: {8{XGMII_ERROR}}, ctrl: 8'hff};
    localparam xgmii_t XGMII_TERM_WORD = '{data: {{7{XGMII_IDLE}}, XGMII_TERM}, ctrl: 8'hff};
    localparam xgmii_t XGMII_PREAMBLE_WORD =
        '{data: {XGMII_SFD, {6{XGMII_PREAMBLE}}, XGMII_START}, ctrl: 8'h01};

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_DATA,
        TX_TERM,
        TX_IFG,
        TX_DRAIN
    } xgmii_tx_state_t;

    typedef struct packed {
        logic [3:0] k;
        logic       bad;
    } keep_info_t;

    // Count of valid lanes on a last beat; anything but 1..8 ones packed from lane 0 is bad.
    function automatic keep_info_t keep_decode(input logic [7:0] keep);
        keep_info_t r;
        r.k   = 4'd0;
        r.bad = 1'b0;
        case (keep)
            8'h01:   r.k = 4'd1;
            8'h03:   r.k = 4'd2;
            8'h07:   r.k = 4'd3;
            8'h0f:   r.k = 4'd4;
            8'h1f:   r.k = 4'd5;
            8'h3f:   r.k = 4'd6;
            8'h7f:   r.k = 4'd7;
            8'hff:   r.k = 4'd8;
            default: r.bad = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/xgmii_tx_encoder.sv
// AXI-Stream to XGMII transmit encoder: adds start/preamble, terminate and
// minimum inter-frame gap, and replaces underrun or malformed beats with /E/.
`timescale 1ns/1ps
module xgmii_tx_encoder
    import xgmii_pkg::*;
#(
    parameter int IFG_BYTES = 12
)
(
    input  logic        clk156,
    input  logic        sys_rst,
    input  logic [63:0] s_axis_tdata,
    input  logic [7:0]  s_axis_tkeep,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output xgmii_t      xgmii_tx,
    output logic        stat_frame,
    output logic        stat_err
);

    xgmii_tx_state_t state_q, state_d;
    xgmii_t          xgmii_q, xgmii_d;
    logic            stat_frame_q, stat_frame_d;
    logic            stat_err_q, stat_err_d;
    logic [1:0]      ifg_cnt_q, ifg_cnt_d;
    logic            term_ok_q, term_ok_d;

    keep_info_t      keep_info;
    logic [63:0]     term_data;
    logic [7:0]      term_ctrl;

    // Idle cycles still owed after the terminate cycle, minus one (b = bytes from T to cycle end).
    function automatic logic [1:0] ifg_load(input logic [3:0] b);
        int n;
        n = (IFG_BYTES - int'(b) + 7) / 8;
        if (n < 1) n = 1;
        if (n > 4) n = 4;
        return 2'(n - 1);
    endfunction

    assign keep_info = keep_decode(s_axis_tkeep);

    // Partial last beat: data below lane k, T in lane k, idles above it.
    for (genvar gi = 0; gi < 8; gi++) begin : g_term_lane
        assign term_data[gi*8 +: 8] = (4'(gi) < keep_info.k) ? s_axis_tdata[gi*8 +: 8] :
                                      (4'(gi) == keep_info.k) ? XGMII_TERM : XGMII_IDLE;
        assign term_ctrl[gi]        = (4'(gi) >= keep_info.k);
    end

    always_comb begin
        state_d       = state_q;
        xgmii_d       = XGMII_IDLE_WORD;
        stat_frame_d  = 1'b0;
        stat_err_d    = 1'b0;
        ifg_cnt_d     = ifg_cnt_q;
        term_ok_d     = term_ok_q;
        s_axis_tready = 1'b0;

        unique case (state_q)
            TX_IDLE: begin
                if (s_axis_tvalid) begin
                    xgmii_d = XGMII_PREAMBLE_WORD;
                    state_d = TX_DATA;
                end
            end

            TX_DATA: begin
                s_axis_tready = 1'b1;
                if (!s_axis_tvalid) begin
                    xgmii_d    = XGMII_ERROR_WORD;
                    stat_err_d = 1'b1;
                    state_d    = TX_DRAIN;
                end else if (!s_axis_tlast) begin
                    if (s_axis_tkeep != 8'hff) begin
                        xgmii_d    = XGMII_ERROR_WORD;
                        stat_err_d = 1'b1;
                        state_d    = TX_DRAIN;
                    end else begin
                        xgmii_d.data = s_axis_tdata;
                        xgmii_d.ctrl = 8'h00;
                    end
                end else if (keep_info.bad) begin
                    // The frame end is known, so still close it with a T, but uncounted.
                    xgmii_d    = XGMII_ERROR_WORD;
                    stat_err_d = 1'b1;
                    term_ok_d  = 1'b0;
                    state_d    = TX_TERM;
                end else if (keep_info.k == 4'd8) begin
                    xgmii_d.data = s_axis_tdata;
                    xgmii_d.ctrl = 8'h00;
                    term_ok_d    = 1'b1;
                    state_d      = TX_TERM;
                end else begin
                    xgmii_d.data = term_data;
                    xgmii_d.ctrl = term_ctrl;
                    stat_frame_d = 1'b1;
                    ifg_cnt_d    = ifg_load(4'd8 - keep_info.k);
                    state_d      = TX_IFG;
                end
            end

            TX_TERM: begin
                xgmii_d      = XGMII_TERM_WORD;
                stat_frame_d = term_ok_q;
                ifg_cnt_d    = ifg_load(4'd8);
                state_d      = TX_IFG;
            end

            TX_IFG: begin
                if (ifg_cnt_q == 2'd0) begin
                    state_d = TX_IDLE;
                end else begin
                    ifg_cnt_d = ifg_cnt_q - 2'd1;
                end
            end

            TX_DRAIN: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_d = TX_IDLE;
                end
            end

            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk156) begin
        if (sys_rst) begin
            state_q      <= TX_IDLE;
            xgmii_q      <= XGMII_IDLE_WORD;
            stat_frame_q <= 1'b0;
            stat_err_q   <= 1'b0;
            ifg_cnt_q    <= 2'd0;
            term_ok_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            xgmii_q      <= xgmii_d;
            stat_frame_q <= stat_frame_d;
            stat_err_q   <= stat_err_d;
            ifg_cnt_q    <= ifg_cnt_d;
            term_ok_q    <= term_ok_d;
        end
    end

    assign xgmii_tx   = xgmii_q;
    assign stat_frame = stat_frame_q;
    assign stat_err   = stat_err_q;

endmodule
